alu_packet_ctrl: RTL

ALU_PACKET_CTRL -- requirements
Module: alu_packet_ctrl

---
 rtl/alu_packet_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_packet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_packet_ctrl
// Purpose  : Parses byte-stream command packets arriving from a UART receiver
//            and either echoes the payload back or runs it through an external
//            ALU as a chain of 32-bit little-endian operands, returning the
//            accumulated result as four bytes.
//
//            Packet layout:
//              byte0 opcode, byte1 reserved, byte2 LEN[7:0], byte3 LEN[15:8]
//              LEN counts the whole packet including the 4-byte header.
//            Opcodes: 0xEC echo, 0xAD add, 0x5B sub, 0x88 mul.
//
// Ports    : clk                 - clock, rising edge
//            rst                 - asynchronous reset, active low
//            rx_tdata_i/tvalid_i - receive byte stream (tready_o back)
//            tx_tdata_o/tvalid_o - transmit byte stream (tready_i back)
//            alu_op_o            - 00 add, 01 sub, 10 mul
//            alu_a_o / alu_b_o   - accumulator / newly assembled operand
//            alu_valid_o         - request, held until alu_ready_i
//            alu_result_i        - result, loaded on alu_result_valid_i
//            err_o               - one-cycle pulse on a malformed packet
//            busy_o              - high whenever a packet is in progress
//
// Revision : 1.0 - initial release
// ============================================================================
module alu_packet_ctrl #(
  parameter int DATA_WIDTH_P = 8,
  parameter int OPND_WIDTH_P = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // receive stream
  input  logic [DATA_WIDTH_P-1:0] rx_tdata_i,
  input  logic                    rx_tvalid_i,
  output logic                    rx_tready_o,
  // transmit stream
  output logic [DATA_WIDTH_P-1:0] tx_tdata_o,
  output logic                    tx_tvalid_o,
  input  logic                    tx_tready_i,
  // ALU request / result
  output logic [1:0]              alu_op_o,
  output logic [OPND_WIDTH_P-1:0] alu_a_o,
  output logic [OPND_WIDTH_P-1:0] alu_b_o,
  output logic                    alu_valid_o,
  input  logic                    alu_ready_i,
  input  logic [OPND_WIDTH_P-1:0] alu_result_i,
  input  logic                    alu_result_valid_i,
  // status
  output logic                    err_o,
  output logic                    busy_o
);

  localparam logic [7:0] c_OP_ECHO = 8'hEC;
  localparam logic [7:0] c_OP_ADD  = 8'hAD;
  localparam logic [7:0] c_OP_SUB  = 8'h5B;
  localparam logic [7:0] c_OP_MUL  = 8'h88;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RSV      = 4'd1,
    S_LEN_LO   = 4'd2,
    S_LEN_HI   = 4'd3,
    S_ECHO     = 4'd4,
    S_OPND     = 4'd5,
    S_ALU_REQ  = 4'd6,
    S_ALU_WAIT = 4'd7,
    S_RESP     = 4'd8,
    S_DRAIN    = 4'd9
  } state_t;

  state_t            r_state;
  logic [7:0]        r_opcode;
  logic [7:0]        r_len_lo;
  logic [15:0]       r_cnt;      // payload bytes still to be accepted
  logic [31:0]       r_acc;
  logic [31:0]       r_opnd;
  logic [1:0]        r_bidx;     // byte lane within an operand / response word
  logic              r_first;    // next completed operand seeds the accumulator
  logic [7:0]        r_hold;     // echo holding register
  logic              r_full;
  logic              r_err;

  logic              w_rx_rdy;
  logic              w_rx_fire;
  logic              w_tx_vld;
  logic              w_tx_fire;
  logic [15:0]       w_len;
  logic [15:0]       w_pay;
  logic              w_is_arith;
  logic [7:0]        w_byte;

  assign w_byte = rx_tdata_i;

  // --------------------------------------------------------------------------
  // Stream handshakes, decoded from the registered state
  // --------------------------------------------------------------------------
  always_comb begin
    w_rx_rdy = 1'b0;
    case (r_state)
      S_IDLE, S_RSV, S_LEN_LO, S_LEN_HI, S_OPND, S_DRAIN: w_rx_rdy = 1'b1;
      // Never pull in a byte past the end of the echo payload: it belongs to
      // the next packet and must reach IDLE as an opcode.
      S_ECHO:  w_rx_rdy = !r_full && (r_cnt != 16'd0);
      default: w_rx_rdy = 1'b0;
    endcase
  end

  // Held low while reset is asserted so nothing is accepted during reset.
  assign rx_tready_o = w_rx_rdy & rst;
  assign w_rx_fire   = rx_tvalid_i & rx_tready_o;

  assign w_tx_vld    = ((r_state == S_ECHO) && r_full) || (r_state == S_RESP);
  assign tx_tvalid_o = w_tx_vld;
  assign w_tx_fire   = w_tx_vld & tx_tready_i;

  assign tx_tdata_o  = (r_state == S_RESP) ? r_acc[{r_bidx, 3'b000} +: 8] : r_hold;

  // --------------------------------------------------------------------------
  // Header decode helpers
  // --------------------------------------------------------------------------
  assign w_len      = {w_byte, r_len_lo};
  assign w_pay      = w_len - 16'd4;   // only meaningful when w_len >= 4
  assign w_is_arith = (r_opcode == c_OP_ADD) || (r_opcode == c_OP_SUB) ||
                      (r_opcode == c_OP_MUL);

  // --------------------------------------------------------------------------
  // ALU-facing outputs
  // --------------------------------------------------------------------------
  always_comb begin
    alu_op_o = 2'b00;
    case (r_opcode)
      c_OP_SUB: alu_op_o = 2'b01;
      c_OP_MUL: alu_op_o = 2'b10;
      default:  alu_op_o = 2'b00;
    endcase
  end

  assign alu_a_o     = r_acc;
  assign alu_b_o     = r_opnd;
  assign alu_valid_o = (r_state == S_ALU_REQ);
  assign err_o       = r_err;
  assign busy_o      = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Packet state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_opcode <= 8'h00;
      r_len_lo <= 8'h00;
      r_cnt    <= 16'h0000;
      r_acc    <= 32'h0000_0000;
      r_opnd   <= 32'h0000_0000;
      r_bidx   <= 2'd0;
      r_first  <= 1'b0;
      r_hold   <= 8'h00;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_opcode <= w_byte;
            r_state  <= S_RSV;
          end
        end

        S_RSV: begin
          if (w_rx_fire) r_state <= S_LEN_LO;
        end

        S_LEN_LO: begin
          if (w_rx_fire) begin
            r_len_lo <= w_byte;
            r_state  <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (w_rx_fire) begin
            r_bidx  <= 2'd0;
            r_first <= 1'b1;
            r_full  <= 1'b0;
            if (w_len < 16'd4) begin
              // Length shorter than its own header: nothing to drain.
              r_cnt   <= 16'd0;
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else if (r_opcode == c_OP_ECHO) begin
              r_cnt   <= w_pay;
              r_state <= (w_pay == 16'd0) ? S_IDLE : S_ECHO;
            end else if (w_is_arith && (w_pay != 16'd0) && (w_pay[1:0] == 2'b00)) begin
              r_cnt   <= w_pay;
              r_state <= S_OPND;
            end else begin
              r_cnt   <= w_pay;
              r_err   <= 1'b1;
              r_state <= (w_pay == 16'd0) ? S_IDLE : S_DRAIN;
            end
          end
        end

        S_ECHO: begin
          // rx_tready is !full, so an accept and a take never hit the same
          // holding-register slot; the later assignment wins when both occur.
          if (w_tx_fire) r_full <= 1'b0;
          if (w_rx_fire) begin
            r_hold <= w_byte;
            r_full <= 1'b1;
            r_cnt  <= r_cnt - 16'd1;
          end
          if (w_tx_fire && !w_rx_fire && (r_cnt == 16'd0)) r_state <= S_IDLE;
        end

        S_OPND: begin
          if (w_rx_fire) begin
            r_opnd[{r_bidx, 3'b000} +: 8] <= w_byte;
            r_bidx <= r_bidx + 2'd1;
            r_cnt  <= r_cnt - 16'd1;
            if (r_bidx == 2'd3) begin
              if (r_first) begin
                r_acc   <= {w_byte, r_opnd[23:0]};
                r_first <= 1'b0;
                // A single-operand packet simply returns that operand.
                if (r_cnt == 16'd1) r_state <= S_RESP;
              end else begin
                r_state <= S_ALU_REQ;
              end
            end
          end
        end

        S_ALU_REQ: begin
          if (alu_ready_i) r_state <= S_ALU_WAIT;
        end

        S_ALU_WAIT: begin
          if (alu_result_valid_i) begin
            r_acc   <= alu_result_i;
            r_bidx  <= 2'd0;
            r_state <= (r_cnt == 16'd0) ? S_RESP : S_OPND;
          end
        end

        S_RESP: begin
          if (w_tx_fire) begin
            r_bidx <= r_bidx + 2'd1;
            if (r_bidx == 2'd3) r_state <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (w_rx_fire) begin
            r_cnt <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
